// File: rtl/mem_access.sv
// MEM pipeline stage: issues word loads/stores over a ready handshake, stalls
// upstream while memory is busy, and drives the MEM/WB register.
module mem_access #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_rst_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  rd_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic        memtoreg_i,
  input  logic        regwrite_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        stall_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_o,
  output logic        regwrite_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   wait_cnt, next_cnt;

  logic [31:0] hold_addr, hold_wdata;
  logic [4:0]  hold_rd;
  logic        hold_we, hold_memtoreg, hold_regwrite;

  logic        access, misaligned, capture;
  logic        req, stall, set_err;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_we;
  logic [31:0] wb_next;
  logic [4:0]  rd_next;
  logic        rw_next;

  assign access     = memread_i | memwrite_i;
  assign misaligned = (alu_rst_i[1:0] != 2'b00);

  // In WAIT the upstream stages are frozen but may still wiggle, so the
  // request is presented from the hold registers.
  assign sel_addr  = (state == S_WAIT) ? hold_addr  : {alu_rst_i[31:2], 2'b00};
  assign sel_wdata = (state == S_WAIT) ? hold_wdata : mem_wdata_i;
  assign sel_we    = (state == S_WAIT) ? hold_we    : memwrite_i;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    next_state = state;
    next_cnt   = wait_cnt;
    req        = 1'b0;
    stall      = 1'b0;
    set_err    = 1'b0;
    capture    = 1'b0;
    wb_next    = 32'h0;
    rd_next    = 5'h0;
    rw_next    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!access) begin
          wb_next = alu_rst_i;
          rd_next = rd_i;
          rw_next = regwrite_i;
        end else if (misaligned) begin
          set_err = 1'b1;
        end else begin
          req     = 1'b1;
          capture = 1'b1;
          if (dmem_ready_i) begin
            wb_next = memtoreg_i ? dmem_rdata_i : alu_rst_i;
            rd_next = rd_i;
            rw_next = regwrite_i;
          end else begin
            stall      = 1'b1;
            next_state = S_WAIT;
            next_cnt   = '0;
          end
        end
      end

      S_WAIT: begin
        req = 1'b1;
        if (dmem_ready_i) begin
          wb_next    = hold_memtoreg ? dmem_rdata_i : hold_addr;
          rd_next    = hold_rd;
          rw_next    = hold_regwrite;
          next_state = S_IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Abort: drop the request and release the pipeline with a bubble.
          set_err    = 1'b1;
          next_state = S_IDLE;
        end else begin
          stall    = 1'b1;
          next_cnt = wait_cnt + 1'b1;
        end
      end

      default: next_state = S_IDLE;
    endcase
  end

  assign dmem_req_o   = req & ~rst;
  assign dmem_we_o    = req & sel_we & ~rst;
  assign stall_o      = stall & ~rst;
  assign dmem_addr_o  = sel_addr;
  assign dmem_wdata_o = sel_wdata;

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the values from before this edge.
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      wb_data_o  <= 32'h0;
      rd_o       <= 5'h0;
      regwrite_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= next_state;
      wait_cnt   <= next_cnt;
      wb_data_o  <= wb_next;
      rd_o       <= rd_next;
      regwrite_o <= rw_next;
      if (set_err) err_o <= 1'b1;
    end
  end

  // NOTE: hold registers need no reset; they are only read in WAIT, which is
  // always entered through a capture edge.
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_addr     <= {alu_rst_i[31:2], 2'b00};
      hold_wdata    <= mem_wdata_i;
      hold_we       <= memwrite_i;
      hold_rd       <= rd_i;
      hold_memtoreg <= memtoreg_i;
      hold_regwrite <= regwrite_i;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized
// instructions checked against a per-instruction behavioural model.
module tb_mem_access;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_rst_i, mem_wdata_i, dmem_rdata_i;
  logic [4:0]  rd_i;
  logic        memread_i, memwrite_i, memtoreg_i, regwrite_i, dmem_ready_i;
  logic        dmem_req_o, dmem_we_o, stall_o, regwrite_o, err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [4:0]  rd_o;

  int tests = 0;
  int fails = 0;
  logic err_model = 1'b0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .alu_rst_i(alu_rst_i), .mem_wdata_i(mem_wdata_i), .rd_i(rd_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i),
    .memtoreg_i(memtoreg_i), .regwrite_i(regwrite_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ready_i(dmem_ready_i),
    .stall_o(stall_o), .wb_data_o(wb_data_o), .rd_o(rd_o),
    .regwrite_o(regwrite_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    alu_rst_i   = $urandom;
    mem_wdata_i = $urandom;
    rd_i        = 5'($urandom);
    memread_i   = 1'($urandom);
    memwrite_i  = 1'($urandom);
    memtoreg_i  = 1'($urandom);
    regwrite_i  = 1'($urandom);
  endtask

  // Presents one instruction starting #1 after a rising edge and returns #1
  // after the edge on which its MEM/WB result is loaded. lat = number of
  // request cycles before ready (lat > TIMEOUT means ready never comes).
  task automatic do_instr(input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rr, input logic mw,
                          input logic mtr, input logic rw, input int lat,
                          input logic [31:0] rdata);
    logic        acc, mis;
    int          n_req, n_stall, n_cyc;
    logic [31:0] exp_wb;
    logic [4:0]  exp_rd;
    logic        exp_rw;
    acc = rr | mw;
    mis = acc && (alu % 4 != 0);
    exp_wb = 0; exp_rd = 0; exp_rw = 0;
    if (!acc) begin
      n_req = 0; n_stall = 0;
      exp_wb = alu; exp_rd = rd; exp_rw = rw;
    end else if (mis) begin
      n_req = 0; n_stall = 0;
      err_model = 1'b1;
    end else if (lat <= TIMEOUT) begin
      n_req = lat + 1; n_stall = lat;
      exp_wb = mtr ? rdata : alu; exp_rd = rd; exp_rw = rw;
    end else begin
      n_req = TIMEOUT + 1; n_stall = TIMEOUT;
      err_model = 1'b1;
    end
    n_cyc = (n_req > 0) ? n_req : 1;

    for (int k = 0; k < n_cyc; k++) begin
      if (k == 0) begin
        alu_rst_i = alu; mem_wdata_i = wd; rd_i = rd;
        memread_i = rr; memwrite_i = mw; memtoreg_i = mtr; regwrite_i = rw;
      end else begin
        scramble_inputs();
      end
      if (n_req == 0) dmem_ready_i = 1'($urandom);
      else            dmem_ready_i = (k == lat);
      dmem_rdata_i = (n_req > 0 && k == lat) ? rdata : $urandom;
      @(negedge clk);
      check("req", dmem_req_o, k < n_req);
      check("stall", stall_o, k < n_stall);
      if (k < n_req) begin
        check("addr", dmem_addr_o, alu & 32'hFFFF_FFFC);
        check("we", dmem_we_o, mw);
        check("wdata", dmem_wdata_o, wd);
      end
      @(posedge clk); #1;
      if (k < n_cyc - 1) begin
        check("bubble_rw", regwrite_o, 1'b0);
        check("bubble_rd", rd_o, 5'd0);
      end
    end
    check("wb_data", wb_data_o, exp_wb);
    check("rd", rd_o, exp_rd);
    check("regwrite", regwrite_o, exp_rw);
    check("err", err_o, err_model);
  endtask

  initial begin
    logic [31:0] a;
    int          sel, lat;
    rst = 1'b1;
    scramble_inputs();
    dmem_ready_i = 1'b0;
    dmem_rdata_i = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem_req_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_wb", wb_data_o, 32'h0);
    check("rst_rd", rd_o, 5'd0);
    check("rst_rw", regwrite_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    rst = 1'b0;

    // Directed cases: pass-through, zero-wait load, 3-wait store
    do_instr(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    do_instr(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'hDEAD_BEEF);
    do_instr(32'h0000_0200, 32'hCAFE_F00D, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h0);
    do_instr(32'h0000_0204, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h1357_9BDF);

    // Random error-free traffic
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      a   = $urandom & 32'hFFFF_FFFC;
      if (sel == 0) a = $urandom;
      do_instr(a, $urandom, 5'($urandom), sel == 1 || sel == 3, sel == 2 || sel == 3,
               1'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom);
    end

    // Ready arriving on the last possible cycle completes rather than aborts
    do_instr(32'h0000_0300, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, TIMEOUT, 32'hA5A5_5A5A);
    // Timeout, then normal pass-through
    do_instr(32'h0000_0400, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, TIMEOUT + 5, 32'h0);
    do_instr(32'h0000_0055, 32'h0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    // Misaligned load
    do_instr(32'h0000_0102, 32'h0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0);

    // Reset during the second WAIT cycle
    alu_rst_i = 32'h0000_0500; mem_wdata_i = 32'h0; rd_i = 5'd15;
    memread_i = 1'b1; memwrite_i = 1'b0; memtoreg_i = 1'b1; regwrite_i = 1'b1;
    dmem_ready_i = 1'b0;
    @(negedge clk);
    check("rw_req0", dmem_req_o, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_stall1", stall_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rw_rst_req", dmem_req_o, 1'b0);
    check("rw_rst_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    err_model = 1'b0;
    check("rw_wb", wb_data_o, 32'h0);
    check("rw_rd", rd_o, 5'd0);
    check("rw_rw", regwrite_o, 1'b0);
    check("rw_err", err_o, 1'b0);

    // Random mixed traffic including misaligned and timeouts
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 3);
      a   = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                        : $urandom_range(0, 4);
      do_instr(a, $urandom, 5'($urandom), sel == 1 || sel == 3, sel == 2 || sel == 3,
               1'($urandom), 1'($urandom), lat, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
